// File: rtl/grf_write_arbiter.sv
// Three-requester round-robin arbiter feeding a single registered GRF write stage,
// with read-port hazard detection and forwarding from that stage.
module grf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  input  logic                  hold,
  output logic                  WriteEnable,
  output logic [ADDR_W-1:0]     WriteAddress,
  output logic [DATA_W-1:0]     WriteData,
  output logic [1:0]            grant_id,
  input  logic [ADDR_W-1:0]     rd_addr1,
  input  logic [ADDR_W-1:0]     rd_addr2,
  output logic                  hit1,
  output logic                  hit2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2,
  output logic [15:0]           wr_count
);

  logic [1:0]        r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_gid;
  logic [15:0]       r_cnt;

  logic              w_gnt;
  logic [1:0]        w_gnt_id;
  logic [1:0]        w_cand;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_gnt_we;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Scan from the farthest candidate back to ptr so the first valid in
  // round-robin order is the last one assigned.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 2'd0;
    w_cand   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      w_cand = wrap3({1'b0, r_ptr} + 3'(k));
      if (!Reset && !hold && req_valid[w_cand]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_cand;
      end
    end
  end

  always_comb begin
    case (w_gnt_id)
      2'd1:    begin
        w_gnt_addr = req_addr[ADDR_W +: ADDR_W];
        w_gnt_data = req_data[DATA_W +: DATA_W];
      end
      2'd2:    begin
        w_gnt_addr = req_addr[2*ADDR_W +: ADDR_W];
        w_gnt_data = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        w_gnt_addr = req_addr[0 +: ADDR_W];
        w_gnt_data = req_data[0 +: DATA_W];
      end
    endcase
  end

  assign w_gnt_we  = w_gnt && (w_gnt_addr != '0);
  assign req_ready = w_gnt ? (3'b001 << w_gnt_id) : 3'b000;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ptr  <= 2'd0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= 2'd3;
      r_cnt  <= 16'd0;
    end else if (w_gnt) begin
      r_ptr  <= (w_gnt_id == 2'd2) ? 2'd0 : w_gnt_id + 2'd1;
      r_addr <= w_gnt_addr;
      r_data <= w_gnt_data;
      r_gid  <= w_gnt_id;
      r_we   <= w_gnt_we;
      if (w_gnt_we) r_cnt <= r_cnt + 16'd1;
    end else begin
      r_we  <= 1'b0;
      r_gid <= 2'd3;
    end
  end

  assign WriteEnable  = r_we;
  assign WriteAddress = r_addr;
  assign WriteData    = r_data;
  assign grant_id     = r_gid;
  assign wr_count     = r_cnt;

  // Register 0 is hardwired, so it never hazards.
  assign hit1      = r_we && (r_addr == rd_addr1) && (rd_addr1 != '0);
  assign hit2      = r_we && (r_addr == rd_addr2) && (rd_addr2 != '0);
  assign fwd_data1 = hit1 ? r_data : '0;
  assign fwd_data2 = hit2 ? r_data : '0;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_grf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            Reset;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic            hold;
  logic            WriteEnable;
  logic [AW-1:0]   WriteAddress;
  logic [DW-1:0]   WriteData;
  logic [1:0]      grant_id;
  logic [AW-1:0]   rd_addr1, rd_addr2;
  logic            hit1, hit2;
  logic [DW-1:0]   fwd_data1, fwd_data2;
  logic [15:0]     wr_count;

  logic [AW-1:0] a_addr [3];
  logic [DW-1:0] a_data [3];
  assign req_addr = {a_addr[2], a_addr[1], a_addr[0]};
  assign req_data = {a_data[2], a_data[1], a_data[0]};

  grf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .grant_id(grant_id), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            m_cnt;
  int            last_g;

  function automatic int exp_grant();
    if (Reset || hold) return -1;
    for (int k = 0; k < 3; k++)
      if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  function automatic bit exp_hit(input logic [AW-1:0] ra);
    return m_we && (m_addr == ra) && (ra != 0);
  endfunction

  task automatic tick();
    int g;
    g = exp_grant();
    last_g = g;
    @(posedge clk);
    if (Reset) begin
      m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_gid = 3; m_cnt = 0;
    end else if (g >= 0) begin
      m_ptr  = (g + 1) % 3;
      m_addr = a_addr[g];
      m_data = a_data[g];
      m_gid  = g;
      m_we   = (a_addr[g] != 0);
      if (m_we) m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_we  = 0;
      m_gid = 3;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; hold = 1; req_valid = 3'b111;
    #1;
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_ready got=%b exp=000", req_ready);
    end
    tick(); tick();
    n_vec++;
    if (WriteEnable !== 1'b0 || WriteAddress !== '0 || WriteData !== '0) begin
      n_err++; $display("FAIL reset_wstage got we=%b a=%0d d=%h exp 0/0/0",
                        WriteEnable, WriteAddress, WriteData);
    end
    n_vec++;
    if (grant_id !== 2'd3 || wr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_gid_cnt got gid=%0d cnt=%0d exp 3/0", grant_id, wr_count);
    end
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_ready_held got=%b exp=000", req_ready);
    end
    Reset = 0; hold = 0; req_valid = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d [4];
    int            exp_g [4];
    exp_d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hAAAA_0001};
    exp_g = '{0, 1, 2, 0};
    for (int i = 0; i < 3; i++) a_addr[i] = 5;
    a_data[0] = 32'hAAAA_0001; a_data[1] = 32'hBBBB_0002; a_data[2] = 32'hCCCC_0003;
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 3'(1 << exp_g[c])) begin
        n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, 3'(1 << exp_g[c]));
      end
      tick();
      n_vec++;
      if (WriteEnable !== 1'b1 || WriteAddress !== 5'd5 || WriteData !== exp_d[c] ||
          grant_id !== 2'(exp_g[c])) begin
        n_err++; $display("FAIL rr_write[%0d] got we=%b a=%0d d=%h g=%0d exp 1/5/%h/%0d",
                          c, WriteEnable, WriteAddress, WriteData, grant_id, exp_d[c], exp_g[c]);
      end
    end
    n_vec++;
    if (wr_count !== 16'd4) begin
      n_err++; $display("FAIL rr_count got=%0d exp=4", wr_count);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_addr_zero();
    a_addr[1] = 0; a_data[1] = 32'hFFFF_FFFF; req_valid = 3'b010;
    #1;
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_err++; $display("FAIL zero_ready got=%b exp=010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    n_vec++;
    if (WriteEnable !== 1'b0 || grant_id !== 2'd1 || wr_count !== 16'd4) begin
      n_err++; $display("FAIL zero_write got we=%b g=%0d cnt=%0d exp 0/1/4",
                        WriteEnable, grant_id, wr_count);
    end
  endtask

  task automatic test_forward();
    a_addr[2] = 7; a_data[2] = 32'h1234_5678; req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    rd_addr1 = 7; rd_addr2 = 8;
    #1;
    n_vec++;
    if (hit1 !== 1'b1 || fwd_data1 !== 32'h1234_5678) begin
      n_err++; $display("FAIL fwd_hit got hit1=%b fwd1=%h exp 1/12345678", hit1, fwd_data1);
    end
    n_vec++;
    if (hit2 !== 1'b0 || fwd_data2 !== '0) begin
      n_err++; $display("FAIL fwd_miss got hit2=%b fwd2=%h exp 0/0", hit2, fwd_data2);
    end
    tick();
    n_vec++;
    if (hit1 !== 1'b0 || fwd_data1 !== '0) begin
      n_err++; $display("FAIL fwd_idle got hit1=%b fwd1=%h exp 0/0", hit1, fwd_data1);
    end
    rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_hold();
    // ptr sits at 0 after the grant to requester 2
    for (int i = 0; i < 3; i++) begin a_addr[i] = 5'(9 + i); a_data[i] = 32'h5000 + i; end
    hold = 1; req_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 3'b000) begin
        n_err++; $display("FAIL hold_ready[%0d] got=%b exp=000", c, req_ready);
      end
      tick();
      n_vec++;
      if (WriteEnable !== 1'b0 || grant_id !== 2'd3) begin
        n_err++; $display("FAIL hold_write[%0d] got we=%b g=%0d exp 0/3", c, WriteEnable, grant_id);
      end
    end
    hold = 0;
    #1;
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL hold_release got=%b exp=001", req_ready);
    end
    tick();
    req_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    a_addr[1] = 3; a_data[1] = 32'hDEAD_0003; req_valid = 3'b010;
    tick();
    n_vec++;
    if (WriteEnable !== 1'b1 || grant_id !== 2'd1) begin
      n_err++; $display("FAIL rmid_grant got we=%b g=%0d exp 1/1", WriteEnable, grant_id);
    end
    Reset = 1;
    #1;
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL rmid_ready got=%b exp=000", req_ready);
    end
    tick();
    n_vec++;
    if (WriteEnable !== 1'b0 || grant_id !== 2'd3 || wr_count !== 16'd0) begin
      n_err++; $display("FAIL rmid_after got we=%b g=%0d cnt=%0d exp 0/3/0",
                        WriteEnable, grant_id, wr_count);
    end
    Reset = 0; req_valid = 3'b000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          a_addr[i]    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
          a_data[i]    = $urandom;
        end
      end
      hold     = ($urandom_range(0, 4) == 0);
      Reset    = ($urandom_range(0, 60) == 0);
      rd_addr1 = $urandom_range(0, 1) ? m_addr : 5'($urandom);
      rd_addr2 = 5'($urandom);
      #1;
      n_vec++;
      if (req_ready !== exp_ready()) begin
        n_err++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready());
      end
      tick();
      if (Reset) req_valid = 3'b000;
      n_vec++;
      if (WriteEnable !== m_we || grant_id !== 2'(m_gid) || wr_count !== 16'(m_cnt) ||
          WriteAddress !== m_addr || WriteData !== m_data) begin
        n_err++; $display("FAIL rand_wstage[%0d] got we=%b g=%0d cnt=%0d a=%0d d=%h exp %b/%0d/%0d/%0d/%h",
                          c, WriteEnable, grant_id, wr_count, WriteAddress, WriteData,
                          m_we, m_gid, m_cnt, m_addr, m_data);
      end
      rd_addr1 = $urandom_range(0, 1) ? m_addr : 5'($urandom);
      #1;
      n_vec++;
      if (hit1 !== exp_hit(rd_addr1) || fwd_data1 !== (exp_hit(rd_addr1) ? m_data : '0) ||
          hit2 !== exp_hit(rd_addr2) || fwd_data2 !== (exp_hit(rd_addr2) ? m_data : '0)) begin
        n_err++; $display("FAIL rand_fwd[%0d] got h1=%b f1=%h h2=%b f2=%h", c, hit1, fwd_data1, hit2, fwd_data2);
      end
    end
    Reset = 0; hold = 0; req_valid = 3'b000; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_wrap();
    Reset = 1; tick(); Reset = 0;
    a_addr[0] = 5'd1; a_data[0] = 32'h0000_00AA; req_valid = 3'b001;
    for (int c = 0; c < 65535; c++) tick();
    n_vec++;
    if (wr_count !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_max got=%0d exp=65535", wr_count);
    end
    tick();
    req_valid = 3'b000;
    n_vec++;
    if (wr_count !== 16'd0 || WriteEnable !== 1'b1) begin
      n_err++; $display("FAIL wrap_zero got cnt=%0d we=%b exp 0/1", wr_count, WriteEnable);
    end
  endtask

  initial begin
    Reset = 1; hold = 0; req_valid = 3'b000; rd_addr1 = 0; rd_addr2 = 0;
    last_g = -1;
    m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_gid = 3; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin a_addr[i] = 0; a_data[i] = 0; end
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_addr_zero();
    test_forward();
    test_hold();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/grf_write_arbiter.md
GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, GRF data width.
REQ-002 Parameter ADDR_W, default 5, GRF register address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  3  per-requester write request (bit i = requester i).
REQ-006 req_addr  input  3*ADDR_W  requester i destination register in bits [i*ADDR_W +: ADDR_W].
REQ-007 req_data  input  3*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  3  one-hot or zero; bit i high = requester i accepted this cycle.
REQ-009 hold  input  1  pipeline freeze; no grants while high.
REQ-010 WriteEnable  output  1  registered GRF write enable.
REQ-011 WriteAddress  output  ADDR_W  registered GRF write address.
REQ-012 WriteData  output  DATA_W  registered GRF write data.
REQ-013 grant_id  output  2  registered index of requester driving the current write stage; 3 = none.
REQ-014 rd_addr1, rd_addr2  input  ADDR_W each  hazard query addresses (GRF read ports).
REQ-015 hit1, hit2  output  1 each  combinational: in-flight write targets rd_addrN.
REQ-016 fwd_data1, fwd_data2  output  DATA_W each  combinational forward value; WriteData when hitN, else 0.
REQ-017 wr_count  output  16  number of GRF writes issued, wraps at 65535 -> 0.

Function
REQ-018 Handshake: a request transfers when req_valid[i] and req_ready[i] are both high on a rising edge; requesters hold addr/data stable until accepted.
REQ-019 req_ready is combinational from req_valid, hold and priority pointer; at most one bit high per cycle.
REQ-020 hold=1 -> req_ready=0; hold=0 and any req_valid -> exactly one grant.
REQ-021 Arbitration: round-robin over 3 requesters; search order starts at ptr, ptr+1, ptr+2 (mod 3).
REQ-022 After a grant to requester g, ptr <= (g+1) mod 3; no grant -> ptr unchanged.
REQ-023 Write stage is one register deep, reloaded every cycle; latency request accept -> WriteEnable = 1 cycle.
REQ-024 On a grant to g: WriteAddress <= addr_g, WriteData <= data_g, grant_id <= g, WriteEnable <= (addr_g != 0).
REQ-025 Grant with addr 0 is consumed (ready high, ptr advances) but produces WriteEnable=0 and no wr_count increment.
REQ-026 No grant in a cycle: WriteEnable <= 0, grant_id <= 3; WriteAddress/WriteData hold previous values.
REQ-027 wr_count increments by 1 on each edge where next WriteEnable is 1.
REQ-028 hitN = WriteEnable && (WriteAddress == rd_addrN) && (rd_addrN != 0); fwd_dataN = hitN ? WriteData : 0.
REQ-029 Queries see only the registered write stage, never same-cycle requests.
REQ-030 Requester held valid across cycles is re-granted only after the other valid requesters each get one turn.

Reset
REQ-031 Reset=1 at a rising edge: WriteEnable=0, WriteAddress=0, WriteData=0, grant_id=3, ptr=0, wr_count=0.
REQ-032 While Reset=1, req_ready=0 regardless of req_valid/hold; Reset overrides hold.
REQ-033 Reset mid-operation discards any granted-but-unwritten entry; its requester is not re-served automatically.

Verification
REQ-034 After reset, req_valid=3'b111, all addr=5, data=A/B/C held 4 cycles -> grants 0,1,2,0; writes A,B,C,A at addr 5 one cycle later; wr_count=4.
REQ-035 req_valid=3'b010, addr=0, data=FFFF_FFFF -> req_ready=3'b010, next cycle WriteEnable=0, grant_id=1, wr_count unchanged.
REQ-036 Requester 2 writes addr 7 data 1234_5678; next cycle rd_addr1=7 -> hit1=1, fwd_data1=1234_5678; rd_addr2=8 -> hit2=0, fwd_data2=0.
REQ-037 hold=1 with req_valid=3'b111 for 3 cycles -> req_ready=0, WriteEnable=0, ptr unchanged; hold drop -> grant to ptr.
REQ-038 Reset asserted the cycle after a grant to requester 1 (addr 3) -> WriteEnable=0 next edge, grant_id=3, wr_count=0.
REQ-039 65536 back-to-back nonzero-address writes -> wr_count wraps to 0.
